// File: rtl/motion_update_velocity_ctrl_if.sv
// Bundles the velocity motion-update controller's request, cache-read and
// velocity-broadcast signals. The master modport is the controller; the
// slave modport is the surrounding cache and broadcast fabric.
//   start                         request to run one velocity update
//   out_rd_cell/_address/_rden    velocity and force cache read request
//   in_particle_info/in_force     cache readouts, 2 cycles after a read
//   in_dst_cell                   destination cell, aligned with readouts
//   out_motion_update_enable      high for the whole broadcast window
//   out_data/_dst_cell/_valid     new velocity and its destination cell
//   out_busy/out_done             run status and completion pulse
interface motion_update_velocity_ctrl_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned CELL_ID_WIDTH = 4
);
  logic                         start;
  logic [3*CELL_ID_WIDTH-1:0]   out_rd_cell;
  logic [ADDR_WIDTH-1:0]        out_rd_address;
  logic                         out_rden;
  logic [3*DATA_WIDTH-1:0]      in_particle_info;
  logic [3*DATA_WIDTH-1:0]      in_force;
  logic [3*CELL_ID_WIDTH-1:0]   in_dst_cell;
  logic                         out_motion_update_enable;
  logic [3*DATA_WIDTH-1:0]      out_data;
  logic [3*CELL_ID_WIDTH-1:0]   out_data_dst_cell;
  logic                         out_data_valid;
  logic                         out_busy;
  logic                         out_done;

  modport master (
    input  start, in_particle_info, in_force, in_dst_cell,
    output out_rd_cell, out_rd_address, out_rden, out_motion_update_enable,
           out_data, out_data_dst_cell, out_data_valid, out_busy, out_done
  );

  modport slave (
    output start, in_particle_info, in_force, in_dst_cell,
    input  out_rd_cell, out_rd_address, out_rden, out_motion_update_enable,
           out_data, out_data_dst_cell, out_data_valid, out_busy, out_done
  );
endinterface

// File: rtl/motion_update_velocity_ctrl.sv
// Velocity motion-update controller. Walks every cell of the grid (z fastest,
// then y, then x), reads the particle count at address 0 and then each
// particle's velocity and force, and broadcasts v + (f >>> DT_SHIFT) with the
// particle's destination cell.
//   clk, rst   single clock, synchronous active-high reset
//   bus        motion_update_velocity_ctrl_if master modport
module motion_update_velocity_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned CELL_ID_WIDTH = 4,
  parameter int unsigned X_DIM         = 3,
  parameter int unsigned Y_DIM         = 3,
  parameter int unsigned Z_DIM         = 3,
  parameter int unsigned DT_SHIFT      = 4
) (
  input  logic clk,
  input  logic rst,
  motion_update_velocity_ctrl_if.master bus
);

  localparam int unsigned CW    = CELL_ID_WIDTH;
  localparam int unsigned VEC_W = 3 * DATA_WIDTH;
  localparam int unsigned CEL_W = 3 * CELL_ID_WIDTH;
  localparam logic [CW-1:0] X_LAST = CW'(X_DIM);
  localparam logic [CW-1:0] Y_LAST = CW'(Y_DIM);
  localparam logic [CW-1:0] Z_LAST = CW'(Z_DIM);
  localparam logic [CW-1:0] ID_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_NUM, S_WAIT_NUM, S_READ_PARTICLES, S_NEXT_CELL, S_DRAIN, S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cx_q, cy_q, cz_q, cx_d, cy_d, cz_d;
  logic                  rden_q, rden_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  rd_s1_q, rd_s2_q;
  logic                  valid_q;
  logic [VEC_W-1:0]      data_q;
  logic [CEL_W-1:0]      dst_q;
  logic [VEC_W-1:0]      vnew_c;
  logic [ADDR_WIDTH-1:0] num_c;
  logic                  last_cell_c;

  assign num_c       = bus.in_particle_info[ADDR_WIDTH-1:0];
  assign last_cell_c = (cx_q == X_LAST) && (cy_q == Y_LAST) && (cz_q == Z_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:           if (bus.start) state_d = S_READ_NUM;
      S_READ_NUM:       state_d = S_WAIT_NUM;
      // Count arrives on the second wait cycle
      S_WAIT_NUM:       if (wait_q == 2'd1)
                          state_d = (num_c == '0) ? S_NEXT_CELL : S_READ_PARTICLES;
      S_READ_PARTICLES: if (addr_q == count_q) state_d = S_NEXT_CELL;
      S_NEXT_CELL:      state_d = last_cell_c ? S_DRAIN : S_READ_NUM;
      // Leave once nothing is left in the cache pipeline
      S_DRAIN:          if (!rd_s1_q && !rd_s2_q) state_d = S_FINISH;
      S_FINISH:         if (wait_q == 2'd2) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Output/counter next values, all registered below
  always_comb begin
    wait_d  = (state_d == state_q) ? wait_q + 2'd1 : 2'd0;
    count_d = count_q;
    addr_d  = '0;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cz_d    = cz_q;
    rden_d  = (state_d == S_READ_NUM) || (state_d == S_READ_PARTICLES);
    busy_d  = (state_d != S_IDLE);
    en_d    = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d  = (state_q == S_FINISH) && (state_d == S_IDLE);

    if ((state_q == S_WAIT_NUM) && (state_d == S_READ_PARTICLES)) count_d = num_c;

    if (state_d == S_READ_PARTICLES)
      addr_d = (state_q == S_READ_PARTICLES) ? addr_q + ADDR_WIDTH'(1) : ADDR_WIDTH'(1);

    if ((state_q == S_IDLE) && (state_d == S_READ_NUM)) begin
      cx_d = ID_ONE;
      cy_d = ID_ONE;
      cz_d = ID_ONE;
    end else if ((state_q == S_NEXT_CELL) && !last_cell_c) begin
      // z wraps into y, y wraps into x
      if (cz_q == Z_LAST) begin
        cz_d = ID_ONE;
        if (cy_q == Y_LAST) begin
          cy_d = ID_ONE;
          cx_d = cx_q + ID_ONE;
        end else begin
          cy_d = cy_q + ID_ONE;
        end
      end else begin
        cz_d = cz_q + ID_ONE;
      end
    end else if (done_d) begin
      cx_d = '0;
      cy_d = '0;
      cz_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cz_q    <= '0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cz_q    <= cz_d;
      rden_q  <= rden_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // Per-component v + (f >>> DT_SHIFT), wrapping at DATA_WIDTH
  always_comb begin
    vnew_c = '0;
    for (int i = 0; i < 3; i++) begin
      vnew_c[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(
        $signed(bus.in_particle_info[i*DATA_WIDTH +: DATA_WIDTH]) +
        ($signed(bus.in_force[i*DATA_WIDTH +: DATA_WIDTH]) >>> DT_SHIFT));
    end
  end

  // Particle-read tracking through the 2-cycle cache plus output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_s1_q <= 1'b0;
      rd_s2_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      dst_q   <= '0;
    end else begin
      rd_s1_q <= rden_q && (addr_q != '0);
      rd_s2_q <= rd_s1_q;
      valid_q <= rd_s2_q;
      data_q  <= rd_s2_q ? vnew_c : '0;
      dst_q   <= rd_s2_q ? bus.in_dst_cell : '0;
    end
  end

  assign bus.out_rd_cell              = {cx_q, cy_q, cz_q};
  assign bus.out_rd_address           = addr_q;
  assign bus.out_rden                 = rden_q;
  assign bus.out_motion_update_enable = en_q;
  assign bus.out_data                 = data_q;
  assign bus.out_data_dst_cell        = dst_q;
  assign bus.out_data_valid           = valid_q;
  assign bus.out_busy                 = busy_q;
  assign bus.out_done                 = done_q;

endmodule

// File: tb/tb_motion_update_velocity_ctrl.sv
// Bench for motion_update_velocity_ctrl on a 2x3x2 grid: a cache model answers
// reads, and a per-cycle monitor compares reads, outputs and timing against
// queues derived from the cell contents.
module tb_motion_update_velocity_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned XD = 2;
  localparam int unsigned YD = 3;
  localparam int unsigned ZD = 2;
  localparam int unsigned SH = 4;
  localparam int NCELL = 12;
  localparam int MAXP  = 8;

  logic clk;
  logic rst;

  motion_update_velocity_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CW)) bus ();

  motion_update_velocity_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CW),
    .X_DIM(XD), .Y_DIM(YD), .Z_DIM(ZD), .DT_SHIFT(SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cell contents
  int           cnt_m [NCELL];
  logic [95:0]  vel_m [NCELL][MAXP];
  logic [95:0]  frc_m [NCELL][MAXP];
  logic [11:0]  dst_m [NCELL][MAXP];

  // Expected streams and observation state
  logic [20:0]  exp_rd[$];
  logic [108:0] exp_out[$];
  int           due_q[$];
  int checks, passes, fails;
  int cyc, nvalid, ndone, fall_cyc, first_vcyc, last_vcyc;
  bit mon_en, en_prev, en_seen;
  logic [95:0] first_data;
  logic [11:0] first_dst;

  function automatic int ci(input int x, input int y, input int z);
    return ((x - 1) * int'(YD) + (y - 1)) * int'(ZD) + (z - 1);
  endfunction

  // New velocity from floor division by 2**SH, wrapped to 32 bits
  function automatic logic [95:0] exp_vel(input logic [95:0] v, input logic [95:0] f);
    logic [95:0] r;
    longint vv, ff, md, s;
    longint dt;
    dt = longint'(1) << SH;
    for (int i = 0; i < 3; i++) begin
      vv = longint'($signed(v[i*32 +: 32]));
      ff = longint'($signed(f[i*32 +: 32]));
      md = ((ff % dt) + dt) % dt;
      s  = vv + (ff - md) / dt;
      r[i*32 +: 32] = s[31:0];
    end
    return r;
  endfunction

  // Cache model: data for a read appears 2 cycles after it is issued
  initial begin
    logic [19:0] h1, h2, cur;
    bit h1v, h2v, curv;
    int x, y, z, a, c;
    h1 = '0; h2 = '0; h1v = 1'b0; h2v = 1'b0;
    bus.in_particle_info = '0;
    bus.in_force = '0;
    bus.in_dst_cell = '0;
    forever begin
      @(posedge clk);
      #1;
      cur  = {bus.out_rd_cell, bus.out_rd_address};
      curv = bus.out_rden;
      x = int'(h2[19:16]); y = int'(h2[15:12]); z = int'(h2[11:8]); a = int'(h2[7:0]);
      bus.in_particle_info = {$urandom, $urandom, $urandom};
      bus.in_force = {$urandom, $urandom, $urandom};
      bus.in_dst_cell = 12'($urandom);
      if (h2v && x >= 1 && x <= int'(XD) && y >= 1 && y <= int'(YD) &&
          z >= 1 && z <= int'(ZD) && a < MAXP) begin
        c = ci(x, y, z);
        if (a == 0) begin
          bus.in_particle_info = 96'(cnt_m[c]);
        end else begin
          bus.in_particle_info = vel_m[c][a];
          bus.in_force = frc_m[c][a];
          bus.in_dst_cell = dst_m[c][a];
        end
      end
      h2 = h1; h2v = h1v;
      h1 = cur; h1v = curv;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 128'({bus.out_rd_cell, bus.out_rd_address, bus.out_rden,
          bus.out_motion_update_enable, bus.out_data_valid, bus.out_busy, bus.out_done}), 128'd0);
    check({tag, "_data"}, 128'({bus.out_data_dst_cell, bus.out_data}), 128'd0);
  endtask

  // One clock cycle; outputs sampled on the falling edge
  task automatic step();
    logic [20:0]  e_rd;
    logic [108:0] e_out;
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (bus.out_rden) begin
        e_rd = (exp_rd.size() > 0) ? exp_rd.pop_front() : 21'd0;
        check("rd_seq", 128'({1'b1, bus.out_rd_cell, bus.out_rd_address}), 128'(e_rd));
        if (bus.out_rd_address != '0) due_q.push_back(cyc + 3);
      end else begin
        check("rd_idle_addr", 128'(bus.out_rd_address), 128'd0);
      end
      while (due_q.size() > 0 && due_q[0] < cyc) check("vld_late", 128'(cyc), 128'(due_q.pop_front()));
      if (bus.out_data_valid) begin
        check("vld_time", 128'(cyc), 128'((due_q.size() > 0) ? due_q.pop_front() : -1));
        check("vld_en", 128'(bus.out_motion_update_enable), 128'd1);
        e_out = (exp_out.size() > 0) ? exp_out.pop_front() : 109'd0;
        check("vel_data", 128'({1'b1, bus.out_data_dst_cell, bus.out_data}), 128'(e_out));
        if (nvalid == 0) begin
          first_data = bus.out_data;
          first_dst  = bus.out_data_dst_cell;
          first_vcyc = cyc;
        end
        last_vcyc = cyc;
        nvalid++;
      end else begin
        check("idle_data", 128'({bus.out_data_dst_cell, bus.out_data}), 128'd0);
      end
      if (en_prev && !bus.out_motion_update_enable) fall_cyc = cyc;
      if (bus.out_motion_update_enable) en_seen = 1'b1;
      if (bus.out_done) begin
        ndone++;
        check("done_lat", 128'(cyc), 128'(fall_cyc + 3));
        check("busy_at_done", 128'(bus.out_busy), 128'd0);
      end
      en_prev = bus.out_motion_update_enable;
    end
  endtask

  task automatic clear_grid();
    for (int c = 0; c < NCELL; c++) cnt_m[c] = 0;
  endtask

  task automatic rand_grid();
    for (int c = 0; c < NCELL; c++) begin
      cnt_m[c] = int'($urandom_range(0, 3));
      for (int a = 1; a < MAXP; a++) begin
        vel_m[c][a] = {$urandom, $urandom, $urandom};
        frc_m[c][a] = {$urandom, $urandom, $urandom};
        dst_m[c][a] = 12'($urandom);
      end
    end
  endtask

  task automatic build_expected();
    int c;
    exp_rd.delete(); exp_out.delete(); due_q.delete();
    for (int x = 1; x <= int'(XD); x++)
      for (int y = 1; y <= int'(YD); y++)
        for (int z = 1; z <= int'(ZD); z++) begin
          c = ci(x, y, z);
          exp_rd.push_back({1'b1, 4'(x), 4'(y), 4'(z), 8'd0});
          for (int a = 1; a <= cnt_m[c]; a++) begin
            exp_rd.push_back({1'b1, 4'(x), 4'(y), 4'(z), 8'(a)});
            exp_out.push_back({1'b1, dst_m[c][a], exp_vel(vel_m[c][a], frc_m[c][a])});
          end
        end
  endtask

  task automatic kick();
    build_expected();
    nvalid = 0; ndone = 0; en_seen = 1'b0; en_prev = 1'b0; fall_cyc = -100;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_start", 128'({bus.out_busy, bus.out_motion_update_enable}), 128'd3);
  endtask

  task automatic run(input int extra_at);
    kick();
    for (int k = 0; k < 3000 && ndone == 0; k++) begin
      bus.start = (k == extra_at) ? 1'b1 : 1'b0;
      step();
    end
    bus.start = 1'b0;
    check("done_seen", 128'(ndone), 128'd1);
    repeat (6) step();
    check("done_once", 128'(ndone), 128'd1);
    check("busy_end", 128'(bus.out_busy), 128'd0);
    check("rd_left", 128'(exp_rd.size()), 128'd0);
    check("out_left", 128'(exp_out.size()), 128'd0);
    check("en_seen", 128'(en_seen), 128'd1);
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0; cyc = 0;
    mon_en = 1'b0; en_prev = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    clear_grid();
    repeat (3) step();
    check_zero("reset_state");
    bus.start = 1'b1;
    step();
    check_zero("start_in_rst");
    bus.start = 1'b0;
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Two particles in the first cell
    rand_grid();
    clear_grid();
    cnt_m[ci(1,1,1)] = 2;
    for (int a = 1; a <= 2; a++) begin
      vel_m[ci(1,1,1)][a] = {32'hFFFF_FFFB, 32'd20, 32'd10};
      frc_m[ci(1,1,1)][a] = {32'd0, 32'hFFFF_FFF0, 32'd32};
    end
    dst_m[ci(1,1,1)][1] = 12'h123;
    dst_m[ci(1,1,1)][2] = 12'h231;
    run(-1);
    check("two_nvalid", 128'(nvalid), 128'd2);
    check("two_consec", 128'(last_vcyc - first_vcyc), 128'd1);
    check("two_data", 128'(first_data), 128'({32'hFFFF_FFFB, 32'd19, 32'd12}));
    check("two_dst", 128'(first_dst), 128'h123);

    // Empty first cell, one particle in the next
    rand_grid();
    clear_grid();
    cnt_m[ci(1,1,2)] = 1;
    run(-1);
    check("skip_nvalid", 128'(nvalid), 128'd1);
    check("skip_dst", 128'(first_dst), 128'(dst_m[ci(1,1,2)][1]));

    // Positive overflow wraps, in the last cell of the grid
    clear_grid();
    cnt_m[ci(2,3,2)] = 1;
    vel_m[ci(2,3,2)][1] = {32'd0, 32'd0, 32'h7FFF_FFFF};
    frc_m[ci(2,3,2)][1] = {32'd0, 32'd0, 32'h0000_0010};
    run(-1);
    check("wrap_vx", 128'(first_data[31:0]), 128'h8000_0000);

    // Fully empty grid
    clear_grid();
    run(-1);
    check("empty_nvalid", 128'(nvalid), 128'd0);

    // Random grids; the last one sees a start pulse while busy
    for (int r = 0; r < 3; r++) begin
      rand_grid();
      run((r == 2) ? 12 : -1);
    end

    // Reset mid-run, then a clean run
    rand_grid();
    kick();
    repeat (15) step();
    mon_en = 1'b0;
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    check_zero("midrst_1");
    bus.start = 1'b0;
    step();
    check_zero("midrst_2");
    rst = 1'b0;
    step();
    check_zero("post_rst");
    mon_en = 1'b1;
    rand_grid();
    run(-1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
